// File: rtl/dwc_requant.sv
// Requantizes four depthwise-conv row sums to int8 lanes and
// queues the packed word in a small first-word-fall-through FIFO.
module dwc_requant #(
    parameter int ACC_W      = 32,
    parameter int SCALE_W    = 16,
    parameter int SHIFT_W    = 5,
    parameter int OUT_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [ACC_W-1:0]              in_sum0,
    input  logic [ACC_W-1:0]              in_sum1,
    input  logic [ACC_W-1:0]              in_sum2,
    input  logic [ACC_W-1:0]              in_sum3,
    input  logic [ACC_W-1:0]              cfg_bias,
    input  logic [SCALE_W-1:0]            cfg_scale,
    input  logic [SHIFT_W-1:0]            cfg_shift,
    input  logic [7:0]                    cfg_zp,
    input  logic                          cfg_relu_en,
    input  logic                          clr_ovf,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [4*OUT_W-1:0]            out_data,
    output logic [3:0]                    out_sat,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          ovf_sticky
);

    localparam int A_W   = ACC_W + 1;
    localparam int P_W   = A_W + SCALE_W + 1;
    localparam int R_W   = P_W + 1;
    localparam int Q_W   = P_W + 2;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int E_W   = 4 * OUT_W + 4;

    localparam logic signed [Q_W-1:0] HI = 127;
    localparam logic signed [Q_W-1:0] LO = -128;

    logic [ACC_W-1:0]        sums [4];
    logic signed [A_W-1:0]   a1 [4];
    logic signed [P_W-1:0]   p2 [4];
    logic                    v1, v2, v3;
    logic [4*OUT_W-1:0]      d3;
    logic [3:0]              s3;

    assign sums[0] = in_sum0;
    assign sums[1] = in_sum1;
    assign sums[2] = in_sum2;
    assign sums[3] = in_sum3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            v1 <= in_valid;
            v2 <= v1;
            v3 <= v2;
        end
    end

    // Datapath registers carry no reset so the multiply maps onto a DSP.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            a1[i] <= $signed({sums[i][ACC_W-1], sums[i]})
                   + $signed({cfg_bias[ACC_W-1], cfg_bias});
            p2[i] <= P_W'(a1[i]) * P_W'($signed({1'b0, cfg_scale}));
        end
    end

    logic [R_W-1:0]          half;
    logic signed [R_W-1:0]   r [4];
    logic signed [Q_W-1:0]   q [4];
    logic signed [Q_W-1:0]   lo;
    logic [4*OUT_W-1:0]      nxt_data;
    logic [3:0]              nxt_sat;

    always_comb begin
        half     = (R_W'(1) << cfg_shift) >> 1;
        lo       = cfg_relu_en ? Q_W'($signed(cfg_zp)) : LO;
        nxt_data = '0;
        nxt_sat  = '0;
        for (int i = 0; i < 4; i++) begin
            r[i] = ($signed({p2[i][P_W-1], p2[i]}) + $signed(half))
                 >>> cfg_shift;
            q[i] = $signed({r[i][R_W-1], r[i]}) + Q_W'($signed(cfg_zp));
            if (q[i] > HI) begin
                nxt_data[i*OUT_W +: OUT_W] = HI[OUT_W-1:0];
                nxt_sat[i]                 = 1'b1;
            end else if (q[i] < lo) begin
                nxt_data[i*OUT_W +: OUT_W] = lo[OUT_W-1:0];
                nxt_sat[i]                 = 1'b1;
            end else begin
                nxt_data[i*OUT_W +: OUT_W] = q[i][OUT_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        d3 <= nxt_data;
        s3 <= nxt_sat;
    end

    logic [E_W-1:0]   mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0] level;
    logic             full, push, pop, drop;
    logic [E_W-1:0]   head;

    assign full       = (level == LVL_W'(FIFO_DEPTH));
    assign pop        = out_valid && out_ready;
    assign push       = v3 && (!full || pop);
    assign drop       = v3 && full && !pop;
    assign out_valid  = (level != '0);
    assign head       = mem[rd_ptr];
    assign out_data   = head[4*OUT_W-1:0];
    assign out_sat    = head[E_W-1 -: 4];
    assign fifo_level = level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {s3, d3};
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            unique case (1'b1)
                push && !pop: level <= level + LVL_W'(1);
                pop && !push: level <= level - LVL_W'(1);
                default:      level <= level;
            endcase
            if (drop)         ovf_sticky <= 1'b1;
            else if (clr_ovf) ovf_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dwc_requant.sv
// Directed bench for dwc_requant: latency, rounding, clamp/ReLU,
// FIFO overflow, full-with-pop and mid-operation reset.
module tb_dwc_requant;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_sum0, in_sum1, in_sum2, in_sum3;
    logic [31:0] cfg_bias;
    logic [15:0] cfg_scale;
    logic [4:0]  cfg_shift;
    logic [7:0]  cfg_zp;
    logic        cfg_relu_en;
    logic        clr_ovf;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_sat;
    logic [2:0]  fifo_level;
    logic        ovf_sticky;

    int n_chk  = 0;
    int n_pass = 0;

    dwc_requant dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_sum0     (in_sum0),
        .in_sum1     (in_sum1),
        .in_sum2     (in_sum2),
        .in_sum3     (in_sum3),
        .cfg_bias    (cfg_bias),
        .cfg_scale   (cfg_scale),
        .cfg_shift   (cfg_shift),
        .cfg_zp      (cfg_zp),
        .cfg_relu_en (cfg_relu_en),
        .clr_ovf     (clr_ovf),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_sat     (out_sat),
        .fifo_level  (fifo_level),
        .ovf_sticky  (ovf_sticky)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic cfg(input logic [31:0] b, input logic [15:0] m,
                       input logic [4:0] sh, input logic [7:0] zp,
                       input logic relu);
        cfg_bias    = b;
        cfg_scale   = m;
        cfg_shift   = sh;
        cfg_zp      = zp;
        cfg_relu_en = relu;
    endtask

    task automatic send(input logic [31:0] s0, input logic [31:0] s1,
                        input logic [31:0] s2, input logic [31:0] s3);
        in_sum0  = s0;
        in_sum1  = s1;
        in_sum2  = s2;
        in_sum3  = s3;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run(input string tag,
                       input logic [31:0] s0, input logic [31:0] s1,
                       input logic [31:0] s2, input logic [31:0] s3,
                       input logic [31:0] exp_d, input logic [3:0] exp_s);
        send(s0, s1, s2, s3);
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        chk({tag, "_valid"}, 64'(out_valid), 64'(1));
        chk({tag, "_data"}, 64'(out_data), 64'(exp_d));
        chk({tag, "_sat"}, 64'(out_sat), 64'(exp_s));
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sum0   = '0;
        in_sum1   = '0;
        in_sum2   = '0;
        in_sum3   = '0;
        clr_ovf   = 1'b0;
        out_ready = 1'b1;
        cfg(32'd24, 16'd16384, 5'd20, 8'd0, 1'b0);
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_data", 64'(out_data), 64'(0));
        chk("rst_sat", 64'(out_sat), 64'(0));
        chk("rst_level", 64'(fifo_level), 64'(0));
        chk("rst_ovf", 64'(ovf_sticky), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        send(32'd1000, 32'd1000, 32'd1000, 32'd1000);
        chk("lat_e0", 64'(out_valid), 64'(0));
        @(negedge clk);
        chk("lat_e1", 64'(out_valid), 64'(0));
        @(negedge clk);
        chk("lat_e2", 64'(out_valid), 64'(0));
        @(negedge clk);
        chk("lat_e3", 64'(out_valid), 64'(1));
        chk("lat_data", 64'(out_data), 64'h1010_1010);
        chk("lat_sat", 64'(out_sat), 64'(0));
        @(negedge clk);
        chk("lat_empty", 64'(out_valid), 64'(0));

        cfg(32'd0, 16'd1, 5'd1, 8'd0, 1'b0);
        run("rnd_sh1", 32'd3, -32'sd3, 32'd5, -32'sd5, 32'hFE03_FF02, 4'b0000);
        cfg(32'd0, 16'd1, 5'd0, 8'd0, 1'b0);
        run("rnd_sh0", 32'd7, -32'sd7, 32'd0, 32'd127, 32'h7F00_F907, 4'b0000);
        run("sat", 32'd100000, -32'sd100000, 32'd127, -32'sd128,
            32'h807F_807F, 4'b0011);
        cfg(32'd0, 16'd1, 5'd0, 8'hF6, 1'b1);
        run("relu", -32'sd50, 32'd20, 32'd200, 32'd0, 32'hF67F_0AF6, 4'b0101);
        cfg(32'd10, 16'd3, 5'd2, 8'd5, 1'b0);
        run("bias", 32'd2, -32'sd20, 32'd0, -32'sd11, 32'h040D_FE0E, 4'b0000);

        cfg(32'd0, 16'd1, 5'd0, 8'd0, 1'b0);
        out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            in_sum0  = 32'(k);
            in_sum1  = '0;
            in_sum2  = '0;
            in_sum3  = '0;
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("ovf_level", 64'(fifo_level), 64'(4));
        chk("ovf_sticky", 64'(ovf_sticky), 64'(1));
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("ovf_word%0d", k), 64'(out_data), 64'(k));
            @(negedge clk);
        end
        chk("ovf_empty", 64'(out_valid), 64'(0));
        chk("ovf_level0", 64'(fifo_level), 64'(0));
        chk("ovf_hold", 64'(ovf_sticky), 64'(1));
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        chk("ovf_clr", 64'(ovf_sticky), 64'(0));

        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            in_sum0  = 32'(k);
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("fp_full", 64'(fifo_level), 64'(4));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("fp_level", 64'(fifo_level), 64'(4));
        chk("fp_ovf", 64'(ovf_sticky), 64'(0));
        out_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            chk($sformatf("fp_word%0d", k), 64'(out_data), 64'(k));
            @(negedge clk);
        end
        chk("fp_empty", 64'(out_valid), 64'(0));

        out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            in_sum0  = 32'(k);
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("mr_pre_level", 64'(fifo_level), 64'(2));
        rst_n = 1'b0;
        #1;
        chk("mr_valid", 64'(out_valid), 64'(0));
        chk("mr_level", 64'(fifo_level), 64'(0));
        chk("mr_data", 64'(out_data), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("mr_post_valid", 64'(out_valid), 64'(0));
        chk("mr_post_level", 64'(fifo_level), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
